// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM encoding,
// parity-mode constants and the bit-vote helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } rx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // 2-of-3 majority used to decide each serial bit
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with registered strobes at the three
// mid-bit sample points and at the last cycle of each bit period.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic mid_m1_o,
    output logic mid_o,
    output logic mid_p1_o,
    output logic end_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned MID   = CLKS_PER_BIT / 2;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (run_i) begin
            cnt_d = (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Strobes are decoded from the next count so they align with cnt_q
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            mid_m1_o <= 1'b0;
            mid_o    <= 1'b0;
            mid_p1_o <= 1'b0;
            end_o    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            mid_m1_o <= run_i && (cnt_d == CNT_W'(MID - 1));
            mid_o    <= run_i && (cnt_d == CNT_W'(MID));
            mid_p1_o <= run_i && (cnt_d == CNT_W'(MID + 1));
            end_o    <= run_i && (cnt_d == CNT_W'(CLKS_PER_BIT - 1));
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised line, majority-voted bits,
// optional parity, 1/2 stop bits and a valid/ready output word with overrun.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    rx_state_e            state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           samp_q, samp_d;
    logic                 skip_q, skip_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 done_c;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, par_err_q, frame_err_q, overrun_q, busy_q;

    logic                 mid_m1, mid, mid_p1, bit_end;
    logic                 rx_s, vote, take;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run_i    (state_q != ST_IDLE),
        .mid_m1_o (mid_m1),
        .mid_o    (mid),
        .mid_p1_o (mid_p1),
        .end_o    (bit_end)
    );

    assign rx_s = sync2_q;
    assign vote = maj3(samp_q[1], samp_q[0], rx_s);
    // The START->DATA hop happens mid start bit; ignore its remaining strobes
    assign take = mid_p1 & ~skip_q;

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        samp_d     = samp_q;
        skip_d     = skip_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        done_c     = 1'b0;

        if (mid_m1)  samp_d[1] = rx_s;
        if (mid)     samp_d[0] = rx_s;
        if (bit_end) skip_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (en && prev_q && !rx_s) begin
                    state_d    = ST_START;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            ST_START: begin
                if (mid) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                        skip_d    = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (take) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY == PAR_NONE) ? ST_STOP : ST_PAR;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PAR: begin
                if (take) begin
                    perr_d  = (^shift_q) ^ vote ^ (PARITY == PAR_ODD);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (take) begin
                    if (!vote) ferr_d = 1'b1;
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        done_c  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!en) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            samp_q     <= '0;
            skip_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= rx;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            samp_q     <= samp_d;
            skip_q     <= skip_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    // Output word: load on completion unless a held word is still pending
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (!en) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (done_c) begin
            if (!valid_q || rx_ready) begin
                data_q      <= shift_q;
                par_err_q   <= perr_q;
                frame_err_q <= ferr_q | ~vote;
                valid_q     <= 1'b1;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = par_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers (8N1/16, 8E2/16, 7O1/8) driven
// by serial frames and checked against a frame-level expectation model.
module tb_uart_rx_param;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] rx_l;
    logic [2:0] rdy;
    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic [2:0] valid, perr, ferr, ovr, busy;

    int checks   = 0;
    int failures = 0;

    // accepted words: {lane[1:0], data[8:0], parity_err, frame_err}
    logic [12:0] got_q[$];

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .rx(rx_l[0]), .rx_data(data_a), .rx_valid(valid[0]),
        .rx_ready(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]), .busy(busy[0]));

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .rx(rx_l[1]), .rx_data(data_b), .rx_valid(valid[1]),
        .rx_ready(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]), .busy(busy[1]));

    uart_rx_param #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .rx(rx_l[2]), .rx_data(data_c), .rx_valid(valid[2]),
        .rx_ready(rdy[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cpb_of(input int ln); return (ln == 2) ? 8 : 16; endfunction
    function automatic int nb_of(input int ln);  return (ln == 2) ? 7 : 8;  endfunction
    function automatic int pm_of(input int ln);  return ln;                 endfunction
    function automatic int ns_of(input int ln);  return (ln == 1) ? 2 : 1;  endfunction

    function automatic logic [8:0] lane_data(input int ln);
        case (ln)
            0:       return {1'b0, data_a};
            1:       return {1'b0, data_b};
            default: return {2'b0, data_c};
        endcase
    endfunction

    // Frame-level model: what a correct receiver reports for one frame
    function automatic logic [12:0] expect_word(input int ln, input logic [8:0] d,
                                                input logic pbit, input logic [1:0] stp);
        logic [8:0] dm;
        logic       pe, fe;
        dm = '0;
        for (int i = 0; i < nb_of(ln); i++) dm[i] = d[i];
        pe = 1'b0;
        if (pm_of(ln) == 1) pe = ((^dm) ^ pbit) != 1'b0;
        if (pm_of(ln) == 2) pe = ((^dm) ^ pbit) != 1'b1;
        fe = 1'b0;
        for (int s = 0; s < ns_of(ln); s++) if (!stp[s]) fe = 1'b1;
        return {2'(ln), dm, pe, fe};
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            if (valid[i] && rdy[i]) got_q.push_back({2'(i), lane_data(i), perr[i], ferr[i]});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int ln, input logic v, input int n);
        rx_l[ln] = v;
        tick(n);
    endtask

    task automatic send(input int ln, input logic [8:0] d, input logic pbit, input logic [1:0] stp);
        int c;
        c = cpb_of(ln);
        drive(ln, 1'b0, c);
        for (int i = 0; i < nb_of(ln); i++) drive(ln, d[i], c);
        if (pm_of(ln) != 0) drive(ln, pbit, c);
        for (int s = 0; s < ns_of(ln); s++) drive(ln, stp[s], c);
        rx_l[ln] = 1'b1;
    endtask

    task automatic wait_q(input int n, input int max_ticks);
        int t;
        t = 0;
        while (got_q.size() < n && t < max_ticks) begin
            tick(1);
            t++;
        end
        tick(4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({lane_data(i), valid[i], perr[i], ferr[i], ovr[i], busy[i]} !== 14'd0) begin
                failures++;
                $display("FAIL reset lane%0d: data=%h v=%b pe=%b fe=%b ovr=%b busy=%b expected all 0",
                         i, lane_data(i), valid[i], perr[i], ferr[i], ovr[i], busy[i]);
            end
        end
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_basic();
        logic [12:0] exp_w, got_w;
        exp_w = expect_word(0, 9'h0A5, 1'b0, 2'b11);
        send(0, 9'h0A5, 1'b0, 2'b11);
        wait_q(1, 96);
        tick(16);
        checks++;
        if (got_q.size() != 1) begin
            failures++;
            $display("FAIL basic_count: got %0d words expected 1", got_q.size());
        end
        if (got_q.size() > 0) begin
            got_w = got_q.pop_front();
            checks++;
            if (got_w !== exp_w) begin
                failures++;
                $display("FAIL basic_word: got %h expected %h", got_w, exp_w);
            end
        end
        got_q.delete();
    endtask

    task automatic test_parity();
        logic [12:0] exp_w, got_w;
        for (int k = 0; k < 4; k++) begin
            int          ln;
            logic [8:0]  d;
            logic        pb;
            ln = (k < 2) ? 1 : 2;
            d  = (k < 2) ? 9'h03C : 9'($urandom);
            pb = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : 1'(k == 2);
            exp_w = expect_word(ln, d, pb, 2'b11);
            send(ln, d, pb, 2'b11);
            wait_q(1, 6 * cpb_of(ln));
            checks++;
            got_w = (got_q.size() > 0) ? got_q.pop_front() : 13'h1FFF;
            if (got_w !== exp_w) begin
                failures++;
                $display("FAIL parity_%0d lane%0d: got %h expected %h", k, ln, got_w, exp_w);
            end
            got_q.delete();
        end
    endtask

    task automatic test_frame_err();
        logic [12:0] exp_w, got_w;
        for (int k = 0; k < 4; k++) begin
            int          ln;
            logic [8:0]  d;
            logic [1:0]  stp;
            ln  = (k < 2) ? 0 : 1;
            d   = (k == 0) ? 9'h055 : (k == 1) ? 9'h00F : 9'h0C3;
            stp = (k == 0) ? 2'b10 : (k == 2) ? 2'b01 : 2'b11;
            exp_w = expect_word(ln, d, ^d[7:0], stp);
            send(ln, d, ^d[7:0], stp);
            wait_q(1, 6 * cpb_of(ln));
            checks++;
            got_w = (got_q.size() > 0) ? got_q.pop_front() : 13'h1FFF;
            if (got_w !== exp_w) begin
                failures++;
                $display("FAIL frame_%0d lane%0d: got %h expected %h", k, ln, got_w, exp_w);
            end
            got_q.delete();
        end
    endtask

    task automatic test_glitch();
        logic        seen;
        logic [12:0] exp_w, got_w;
        seen = 1'b0;
        drive(0, 1'b0, 4);
        rx_l[0] = 1'b1;
        for (int t = 0; t < 40; t++) begin
            tick(1);
            if (busy[0]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1 || busy[0] !== 1'b0 || got_q.size() != 0) begin
            failures++;
            $display("FAIL glitch: busy_seen=%b busy_now=%b words=%0d expected 1 0 0",
                     seen, busy[0], got_q.size());
        end
        got_q.delete();
        exp_w = expect_word(0, 9'h081, 1'b0, 2'b11);
        send(0, 9'h081, 1'b0, 2'b11);
        wait_q(1, 96);
        checks++;
        got_w = (got_q.size() > 0) ? got_q.pop_front() : 13'h1FFF;
        if (got_w !== exp_w) begin
            failures++;
            $display("FAIL glitch_next: got %h expected %h", got_w, exp_w);
        end
        got_q.delete();
    endtask

    task automatic test_overrun();
        logic [12:0] exp_w, got_w;
        rdy[0] = 1'b0;
        send(0, 9'h011, 1'b0, 2'b11);
        send(0, 9'h022, 1'b0, 2'b11);
        tick(32);
        checks++;
        if (valid[0] !== 1'b1 || data_a !== 8'h11 || ovr[0] !== 1'b1 || got_q.size() != 0) begin
            failures++;
            $display("FAIL overrun_hold: v=%b data=%h ovr=%b words=%0d expected 1 11 1 0",
                     valid[0], data_a, ovr[0], got_q.size());
        end
        rdy[0] = 1'b1;
        tick(3);
        exp_w = expect_word(0, 9'h011, 1'b0, 2'b11);
        checks++;
        got_w = (got_q.size() == 1) ? got_q.pop_front() : 13'h1FFF;
        if (got_w !== exp_w || valid[0] !== 1'b0 || ovr[0] !== 1'b1) begin
            failures++;
            $display("FAIL overrun_xfer: word=%h v=%b ovr=%b expected %h 0 1",
                     got_w, valid[0], ovr[0], exp_w);
        end
        en = 1'b0;
        tick(1);
        checks++;
        if (ovr[0] !== 1'b0 || valid[0] !== 1'b0 || data_a !== 8'h11) begin
            failures++;
            $display("FAIL overrun_clear: ovr=%b v=%b data=%h expected 0 0 11", ovr[0], valid[0], data_a);
        end
        en = 1'b1;
        tick(2);
        got_q.delete();
    endtask

    task automatic test_enable();
        drive(2, 1'b0, 8);
        drive(2, 1'b1, 8);
        en = 1'b0;
        rx_l[2] = 1'b1;
        tick(1);
        checks++;
        if (busy[2] !== 1'b0) begin
            failures++;
            $display("FAIL enable_idle: busy=%b expected 0", busy[2]);
        end
        en = 1'b1;
        tick(40);
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("FAIL enable_drop: words=%0d expected 0", got_q.size());
        end
        got_q.delete();
    endtask

    task automatic test_reset_midframe();
        logic [12:0] exp_w, got_w;
        logic [7:0]  f0;
        f0 = 8'hF0;
        drive(0, 1'b0, 16);
        for (int i = 0; i < 3; i++) drive(0, f0[i], 16);
        drive(0, f0[3], 8);
        rst_n   = 1'b0;
        rx_l[0] = 1'b1;
        tick(2);
        checks++;
        if ({data_a, valid[0], perr[0], ferr[0], ovr[0], busy[0]} !== 13'd0) begin
            failures++;
            $display("FAIL midreset: data=%h v=%b pe=%b fe=%b ovr=%b busy=%b expected all 0",
                     data_a, valid[0], perr[0], ferr[0], ovr[0], busy[0]);
        end
        rst_n = 1'b1;
        tick(40);
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_drop: words=%0d expected 0", got_q.size());
        end
        got_q.delete();
        exp_w = expect_word(0, 9'h09C, 1'b0, 2'b11);
        send(0, 9'h09C, 1'b0, 2'b11);
        wait_q(1, 96);
        checks++;
        got_w = (got_q.size() > 0) ? got_q.pop_front() : 13'h1FFF;
        if (got_w !== exp_w) begin
            failures++;
            $display("FAIL midreset_next: got %h expected %h", got_w, exp_w);
        end
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp_q[$];
        logic [12:0] got_w, exp_w;
        for (int k = 0; k < 6; k++) begin
            int         ln;
            logic [8:0] d;
            logic       pb;
            ln = (k < 3) ? 1 : 2;
            d  = 9'($urandom);
            pb = 1'($urandom_range(0, 1));
            exp_q.push_back(expect_word(ln, d, pb, 2'b11));
            send(ln, d, pb, 2'b11);
        end
        wait_q(6, 200);
        checks++;
        if (got_q.size() != 6) begin
            failures++;
            $display("FAIL b2b_count: got %0d words expected 6", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            got_w = got_q.pop_front();
            exp_w = exp_q.pop_front();
            checks++;
            if (got_w !== exp_w) begin
                failures++;
                $display("FAIL b2b_word: got %h expected %h", got_w, exp_w);
            end
        end
        got_q.delete();
    endtask

    task automatic test_random();
        logic [12:0] exp_w, got_w;
        for (int k = 0; k < 24; k++) begin
            int         ln;
            logic [8:0] d;
            logic       pb;
            logic [1:0] stp;
            ln  = k % 3;
            d   = 9'($urandom);
            pb  = 1'($urandom_range(0, 1));
            stp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            exp_w = expect_word(ln, d, pb, stp);
            send(ln, d, pb, stp);
            wait_q(1, 6 * cpb_of(ln));
            checks++;
            got_w = (got_q.size() == 1) ? got_q.pop_front() : 13'h1FFF;
            if (got_w !== exp_w) begin
                failures++;
                $display("FAIL random_%0d lane%0d: got %h expected %h", k, ln, got_w, exp_w);
            end
            got_q.delete();
            tick($urandom_range(0, 20));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        rx_l  = 3'b111;
        rdy   = 3'b111;
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_enable();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
